// File: rtl/bmp280_pkg.sv
// Shared constants and FSM encoding for the BMP280 temperature compensation stage.
package bmp280_pkg;

  localparam int unsigned TCOMP_LATENCY = 59;
  localparam int unsigned MUL_CYCLES    = 18;

  localparam int unsigned OP_A_W = 24;
  localparam int unsigned OP_B_W = 18;
  localparam int unsigned PROD_W = 42;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StM1,
    StM2,
    StM3,
    StOut
  } tcomp_state_e;

endpackage

// File: rtl/bmp280_tcomp_if.sv
// Bundle between the I2C reader (master) and the temperature compensation stage (slave).
interface bmp280_tcomp_if;

  logic               valid_in;
  logic [19:0]        adc_t;
  logic [15:0]        dig_t1;
  logic [15:0]        dig_t2;
  logic [15:0]        dig_t3;
  logic               busy;
  logic               t_valid;
  logic signed [31:0] t_fine;
  logic signed [31:0] t_centi;
  logic               overrun;

  modport master (
    output valid_in, adc_t, dig_t1, dig_t2, dig_t3,
    input  busy, t_valid, t_fine, t_centi, overrun
  );

  modport slave (
    input  valid_in, adc_t, dig_t1, dig_t2, dig_t3,
    output busy, t_valid, t_fine, t_centi, overrun
  );

endinterface

// File: rtl/bmp280_smul.sv
// Sequential signed radix-2 shift-add multiplier, 24x18 operands, one bit of B per cycle.
module bmp280_smul
  import bmp280_pkg::*;
#(
  parameter int unsigned Cycles = MUL_CYCLES
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start_i,
  input  logic signed [OP_A_W-1:0] a_i,
  input  logic signed [OP_B_W-1:0] b_i,
  output logic                     done_o,
  output logic signed [31:0]       p_o
);

  // Only the low 32 bits of the product are ever consumed, so the accumulator keeps just those.
  logic signed [31:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [OP_B_W-1:0]  mplier_q, mplier_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               run_q, run_d, done_q, done_d;
  logic               last;

  assign last = (cnt_q == 5'(Cycles - 1));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = 32'(a_i);
      mplier_d = b_i;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      // B's MSB carries negative weight, so its partial product is subtracted.
      if (mplier_q[0]) acc_d = last ? acc_q - mcand_q : acc_q + mcand_q;
      mcand_d  = mcand_q <<< 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (last) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done_o = done_q;
  assign p_o    = acc_q;

endmodule

// File: rtl/bmp280_tcomp.sv
// BMP280 temperature compensation: Bosch int32 formula evaluated on one shared multiplier.
module bmp280_tcomp
  import bmp280_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = bmp280_pkg::MUL_CYCLES
) (
  input logic              clk,
  input logic              rstn,
  bmp280_tcomp_if.slave    bus
);

  tcomp_state_e state_q, state_d;

  logic               valid_in_q, valid_in_d;
  logic [19:0]        adc_q, adc_d;
  logic [15:0]        t1_q, t1_d;
  logic signed [15:0] t2_q, t2_d, t3_q, t3_d;
  logic signed [31:0] var1_q, var1_d, tf_acc_q, tf_acc_d;
  logic signed [31:0] t_fine_q, t_fine_d, t_centi_q, t_centi_d;
  logic               busy_q, busy_d, t_valid_q, t_valid_d, overrun_q, overrun_d;

  logic                     rise;
  logic signed [OP_A_W-1:0] d1, d2, mul_a;
  logic signed [OP_B_W-1:0] mul_b;
  logic                     mul_start, mul_done;
  logic signed [31:0]       prod, tf5;

  assign rise = bus.valid_in & ~valid_in_q;
  assign d1   = OP_A_W'(adc_q >> 3) - OP_A_W'({t1_q, 1'b0});
  assign d2   = OP_A_W'(adc_q >> 4) - OP_A_W'(t1_q);
  assign tf5  = (tf_acc_q <<< 2) + tf_acc_q;

  bmp280_smul #(
    .Cycles (MUL_CYCLES)
  ) u_smul (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (mul_start),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .done_o  (mul_done),
    .p_o     (prod)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rise) state_d = StPrep;
      StPrep:  state_d = StM1;
      StM1:    if (mul_done) state_d = StM2;
      StM2:    if (mul_done) state_d = StM3;
      StM3:    if (mul_done) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_in_d = bus.valid_in;
    adc_d      = adc_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    t3_d       = t3_q;
    var1_d     = var1_q;
    tf_acc_d   = tf_acc_q;
    t_fine_d   = t_fine_q;
    t_centi_d  = t_centi_q;
    busy_d     = busy_q;
    t_valid_d  = 1'b0;
    overrun_d  = rise && (state_q != StIdle);
    mul_start  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          adc_d  = bus.adc_t;
          t1_d   = bus.dig_t1;
          t2_d   = bus.dig_t2;
          t3_d   = bus.dig_t3;
          busy_d = 1'b1;
        end
      end
      StPrep: begin
        mul_start = 1'b1;
        mul_a     = d1;
        mul_b     = OP_B_W'(t2_q);
      end
      StM1: begin
        mul_start = mul_done;
        mul_a     = d2;
        mul_b     = OP_B_W'(d2);
        if (mul_done) var1_d = prod >>> 11;
      end
      StM2: begin
        // The product in this cycle is sq = d2*d2, already wrapped to 32 bits.
        mul_start = mul_done;
        mul_a     = OP_A_W'(prod >>> 12);
        mul_b     = OP_B_W'(t3_q);
      end
      StM3: begin
        if (mul_done) tf_acc_d = var1_q + (prod >>> 14);
      end
      StOut: begin
        t_fine_d  = tf_acc_q;
        t_centi_d = (tf5 + 32'sd128) >>> 8;
        t_valid_d = 1'b1;
        busy_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // Resetting the edge detector high means a level already present at release is no edge.
      valid_in_q <= 1'b1;
      adc_q      <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      t3_q       <= '0;
      var1_q     <= '0;
      tf_acc_q   <= '0;
      t_fine_q   <= '0;
      t_centi_q  <= '0;
      busy_q     <= 1'b0;
      t_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_in_q <= valid_in_d;
      adc_q      <= adc_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      t3_q       <= t3_d;
      var1_q     <= var1_d;
      tf_acc_q   <= tf_acc_d;
      t_fine_q   <= t_fine_d;
      t_centi_q  <= t_centi_d;
      busy_q     <= busy_d;
      t_valid_q  <= t_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.t_valid = t_valid_q;
  assign bus.t_fine  = t_fine_q;
  assign bus.t_centi = t_centi_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_bmp280_tcomp.sv
// Scoreboard bench for bmp280_tcomp: directed datasheet vectors, overrun/reset cases, random runs.
module tb_bmp280_tcomp;
  import bmp280_pkg::*;

  typedef struct {
    int tf;
    int tc;
    int cyc;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   fails;
  int   ovr_cnt;
  exp_t sb[$];

  bmp280_tcomp_if bus ();

  bmp280_tcomp #(
    .MUL_CYCLES (18)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bosch int32 reference, straight from the formula with wrapping int arithmetic.
  function automatic void model(input logic [19:0] adc, input logic [15:0] t1,
                                input logic [15:0] t2, input logic [15:0] t3,
                                output int tf, output int tc);
    int a, u1, s2, s3, v1, v2, d;
    a  = int'({12'd0, adc});
    u1 = int'({16'd0, t1});
    s2 = int'($signed(t2));
    s3 = int'($signed(t3));
    v1 = (((a >>> 3) - (u1 <<< 1)) * s2) >>> 11;
    d  = (a >>> 4) - u1;
    v2 = (((d * d) >>> 12) * s3) >>> 14;
    tf = v1 + v2;
    tc = (tf * 5 + 128) >>> 8;
  endfunction

  // Monitor: pops the scoreboard on every t_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.overrun) ovr_cnt++;
        if (bus.t_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected t_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("t_fine", bus.t_fine, e.tf);
            chk("t_centi", bus.t_centi, e.tc);
            chk("latency", cyc, e.cyc);
            chk("busy at t_valid", bus.busy, 0);
          end
        end
      end
    end
  end

  task automatic scramble();
    bus.adc_t  = 20'($urandom);
    bus.dig_t1 = 16'($urandom);
    bus.dig_t2 = 16'($urandom);
    bus.dig_t3 = 16'($urandom);
  endtask

  // Raise valid_in at a negedge; the next posedge samples the edge. Drops it a cycle later.
  task automatic start_conv(input logic [19:0] adc, input logic [15:0] t1, input logic [15:0] t2,
                            input logic [15:0] t3, input bit push, input int tf, input int tc);
    exp_t e;
    @(negedge clk);
    bus.adc_t    = adc;
    bus.dig_t1   = t1;
    bus.dig_t2   = t2;
    bus.dig_t3   = t3;
    bus.valid_in = 1'b1;
    if (push) begin
      e.tf  = tf;
      e.tc  = tc;
      e.cyc = cyc + 1 + int'(TCOMP_LATENCY);
      sb.push_back(e);
    end
    @(negedge clk);
    scramble();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int tf, tc, ovr0;
    logic [19:0] adc;
    logic [15:0] t1, t2, t3;
    cyc          = 0;
    checks       = 0;
    fails        = 0;
    ovr_cnt      = 0;
    rstn         = 1'b0;
    bus.valid_in = 1'b1;
    scramble();
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset t_valid", bus.t_valid, 0);
    chk("reset overrun", bus.overrun, 0);
    chk("reset t_fine", bus.t_fine, 0);
    chk("reset t_centi", bus.t_centi, 0);
    rstn = 1'b1;
    // valid_in high across reset release must not start a conversion
    repeat (5) @(negedge clk);
    chk("no start on held level", bus.busy, 0);
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);

    start_conv(20'd519888, 16'd27504, 16'd26435, 16'hFC18, 1'b1, 128422, 2508);
    bus.valid_in = 1'b0;
    chk("busy after capture", bus.busy, 1);
    drain("datasheet drained");

    start_conv(20'd0, 16'd27504, 16'd26435, 16'hFC18, 1'b1, -721301, -14088);
    bus.valid_in = 1'b0;
    drain("adc zero drained");

    start_conv(20'd440064, 16'd27504, 16'd26435, 16'hFC18, 1'b1, 0, 0);
    bus.valid_in = 1'b0;
    drain("d zero drained");

    // Second edge while busy is dropped; level then held for 200 cycles.
    ovr0 = ovr_cnt;
    start_conv(20'd519888, 16'd27504, 16'd26435, 16'hFC18, 1'b1, 128422, 2508);
    bus.valid_in = 1'b0;
    repeat (8) @(negedge clk);
    bus.valid_in = 1'b1;
    bus.adc_t    = 20'd0;
    repeat (200) @(negedge clk);
    bus.valid_in = 1'b0;
    drain("overrun drained");
    chk("overrun pulses", ovr_cnt - ovr0, 1);

    // Reset at cycle 30 of a conversion aborts it with no t_valid.
    start_conv(20'd519888, 16'd27504, 16'd26435, 16'hFC18, 1'b0, 0, 0);
    bus.valid_in = 1'b0;
    repeat (28) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort t_fine", bus.t_fine, 0);
    chk("abort t_centi", bus.t_centi, 0);
    chk("abort t_valid", bus.t_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (80) @(negedge clk);
    start_conv(20'd0, 16'd27504, 16'd26435, 16'hFC18, 1'b1, -721301, -14088);
    bus.valid_in = 1'b0;
    drain("post reset drained");

    for (int i = 0; i < 1000; i++) begin
      adc = 20'($urandom);
      t1  = 16'($urandom);
      t2  = 16'($urandom);
      t3  = 16'($urandom);
      model(adc, t1, t2, t3, tf, tc);
      start_conv(adc, t1, t2, t3, 1'b1, tf, tc);
      bus.valid_in = 1'b0;
      drain("random drained");
    end

    chk("total overruns", ovr_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
